spi_slave_frame: RTL and testbench

SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

---
 rtl/spi_slave_frame_if.sv | 23 ++
 rtl/spi_slave_frame.sv | 128 ++++++++++++
 tb/tb_spi_slave_frame.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_frame_if.sv
// rtl/spi_slave_frame_if.sv - parallel fetch/transmit side of the SPI slave frame receiver
interface spi_slave_frame_if #(
   parameter int LEN_SPI = 32
);
   logic [LEN_SPI-1:0] rx_output;
   logic               rdy_spi;
   logic               spi_busy;
   logic               ack_fetch_spi;
   logic [LEN_SPI-1:0] tx_input;
   logic               push_tx;
   logic               frame_err;
   logic               overrun;

   modport slave (
      output rx_output, rdy_spi, spi_busy, frame_err, overrun,
      input  ack_fetch_spi, tx_input, push_tx
   );

   modport master (
      input  rx_output, rdy_spi, spi_busy, frame_err, overrun,
      output ack_fetch_spi, tx_input, push_tx
   );
endinterface

// File: rtl/spi_slave_frame.sv
// rtl/spi_slave_frame.sv - SPI mode-0 slave receiving fixed-length frames into a fetch register
module spi_slave_frame #(
   parameter int LEN_SPI = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   spi_slave_frame_if.slave  host
);
   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

   localparam logic [5:0] LAST_BIT = 6'(LEN_SPI - 1);

   state_t state, next_state;

   // [0],[1] synchronizer stages, [2] history flop for edge detection
   logic [2:0] sclk_p, cs_p, mosi_p;

   logic [5:0]         bit_cnt;
   logic [LEN_SPI-1:0] rx_sr;
   logic [LEN_SPI-1:0] tx_sr;
   logic [LEN_SPI-1:0] rx_q;
   logic               rdy_q, err_q, ovr_q;

   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic start, commit, short_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_p <= '0;
         cs_p   <= '0;
         mosi_p <= '0;
      end else begin
         sclk_p <= {sclk_p[1:0], sclk};
         cs_p   <= {cs_p[1:0], cs_n};
         mosi_p <= {mosi_p[1:0], mosi};
      end
   end

   assign sclk_rise = sclk_p[1] & ~sclk_p[2];
   assign sclk_fall = ~sclk_p[1] & sclk_p[2];
   assign cs_fall   = ~cs_p[1] & cs_p[2];
   assign cs_rise   = cs_p[1] & ~cs_p[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      start       = 1'b0;
      commit      = 1'b0;
      short_frame = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               next_state = SHIFT;
               start      = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               next_state  = IDLE;
               short_frame = 1'b1;
            end else if (sclk_rise && bit_cnt == LAST_BIT) begin
               next_state = FULL;
            end
         end
         FULL: begin
            if (cs_rise) begin
               next_state = IDLE;
               commit     = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // mosi_p[2] lags sclk_p[1] by one clk, so it is the bit settled before the detected rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
         tx_sr   <= '0;
      end else if (start) begin
         bit_cnt <= '0;
         tx_sr   <= host.push_tx ? host.tx_input : '0;
      end else if (state == SHIFT) begin
         if (sclk_rise) begin
            bit_cnt <= bit_cnt + 6'd1;
            rx_sr   <= {rx_sr[LEN_SPI-2:0], mosi_p[2]};
         end
         if (sclk_fall) begin
            tx_sr <= {tx_sr[LEN_SPI-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q  <= '0;
         rdy_q <= 1'b0;
         err_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         err_q <= short_frame;
         ovr_q <= 1'b0;
         if (commit) begin
            rx_q  <= rx_sr;
            rdy_q <= 1'b1;
            ovr_q <= rdy_q & ~host.ack_fetch_spi;
         end else if (host.ack_fetch_spi) begin
            rdy_q <= 1'b0;
         end
      end
   end

   assign miso           = (state == SHIFT) ? tx_sr[LEN_SPI-1] : 1'b0;
   assign host.rx_output = rx_q;
   assign host.rdy_spi   = rdy_q;
   assign host.spi_busy  = (state != IDLE);
   assign host.frame_err = err_q;
   assign host.overrun   = ovr_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb/tb_spi_slave_frame.sv - directed table-driven bench for spi_slave_frame
module tb_spi_slave_frame;
   logic clk = 1'b0;
   logic rst_n;
   logic sclk, cs_n, mosi, miso;

   int n_cmp  = 0;
   int n_fail = 0;

   spi_slave_frame_if #(.LEN_SPI(32)) host_if ();

   spi_slave_frame #(.LEN_SPI(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sclk  (sclk),
      .cs_n  (cs_n),
      .mosi  (mosi),
      .miso  (miso),
      .host  (host_if)
   );

   always #13 clk = ~clk;

   typedef struct {
      int          nbits;
      logic [63:0] data;
      logic        push;
      logic [31:0] tx;
      logic        ack_commit;
      logic        ack_after;
      logic        rdy_before;
      logic [31:0] exp_rx;
      logic        exp_rdy;
      logic        exp_err;
      logic        exp_ovr;
      logic [63:0] exp_miso;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic spi_shift(input logic [63:0] d, input int n, output logic [63:0] cap);
      cap  = '0;
      cs_n = 1'b0;
      #300;
      for (int i = 0; i < n; i++) begin
         mosi = d[n-1-i];
         #156;
         cap  = {cap[62:0], miso};
         sclk = 1'b1;
         #156;
         sclk = 1'b0;
      end
      mosi = 1'b0;
      #200;
   endtask

   task automatic end_frame(input logic rdy_before, input logic ack_c);
      @(posedge clk);
      #5 cs_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy_edge2", {63'd0, host_if.spi_busy}, 64'd1);
      check("rdy_edge2", {63'd0, host_if.rdy_spi}, {63'd0, rdy_before});
      if (ack_c) host_if.ack_fetch_spi = 1'b1;
      @(posedge clk); #1;
      host_if.ack_fetch_spi = 1'b0;
      check("busy_commit", {63'd0, host_if.spi_busy}, 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rx"},   {32'd0, host_if.rx_output}, 64'd0);
      check({tag, "_rdy"},  {63'd0, host_if.rdy_spi},   64'd0);
      check({tag, "_busy"}, {63'd0, host_if.spi_busy},  64'd0);
      check({tag, "_miso"}, {63'd0, miso},              64'd0);
      check({tag, "_err"},  {63'd0, host_if.frame_err}, 64'd0);
      check({tag, "_ovr"},  {63'd0, host_if.overrun},   64'd0);
   endtask

   initial begin
      logic [63:0] cap;

      vecs[0] = '{32, 64'h2800_0000,    1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h2800_0000, 1'b1, 1'b0, 1'b0, 64'h0};
      vecs[1] = '{32, 64'h0400_0001,    1'b1, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0, 32'h0400_0001, 1'b1, 1'b0, 1'b0, 64'h0000_A5A5};
      vecs[2] = '{32, 64'h0800_0002,    1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0800_0002, 1'b1, 1'b0, 1'b1, 64'h0};
      vecs[3] = '{20, 64'h000A_BCDE,    1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0800_0002, 1'b1, 1'b1, 1'b0, 64'h0};
      vecs[4] = '{40, 64'h12_3456_789A, 1'b1, 32'hC3C3_C3C3, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 64'hC3_C3C3_C300};
      vecs[5] = '{32, 64'hFFFF_FFFF,    1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF};

      rst_n = 1'b0;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      host_if.ack_fetch_spi = 1'b0;
      host_if.push_tx       = 1'b0;
      host_if.tx_input      = '0;
      #100;
      check_idle_outputs("reset");
      @(posedge clk);
      #5 rst_n = 1'b1;
      #300;

      for (int v = 0; v < 6; v++) begin
         host_if.push_tx  = vecs[v].push;
         host_if.tx_input = vecs[v].push ? vecs[v].tx : 32'hFFFF_FFFF;
         spi_shift(vecs[v].data, vecs[v].nbits, cap);
         host_if.push_tx  = 1'b0;
         end_frame(vecs[v].rdy_before, vecs[v].ack_commit);
         check($sformatf("v%0d_rx", v),   {32'd0, host_if.rx_output}, {32'd0, vecs[v].exp_rx});
         check($sformatf("v%0d_rdy", v),  {63'd0, host_if.rdy_spi},   {63'd0, vecs[v].exp_rdy});
         check($sformatf("v%0d_err", v),  {63'd0, host_if.frame_err}, {63'd0, vecs[v].exp_err});
         check($sformatf("v%0d_ovr", v),  {63'd0, host_if.overrun},   {63'd0, vecs[v].exp_ovr});
         check($sformatf("v%0d_miso", v), cap, vecs[v].exp_miso);
         @(posedge clk); #1;
         check($sformatf("v%0d_err_pulse", v), {63'd0, host_if.frame_err}, 64'd0);
         check($sformatf("v%0d_ovr_pulse", v), {63'd0, host_if.overrun},   64'd0);
         check($sformatf("v%0d_rx_hold", v),   {32'd0, host_if.rx_output}, {32'd0, vecs[v].exp_rx});
         if (vecs[v].ack_after) begin
            host_if.ack_fetch_spi = 1'b1;
            @(posedge clk); #1;
            host_if.ack_fetch_spi = 1'b0;
            check($sformatf("v%0d_ack_clr", v), {63'd0, host_if.rdy_spi}, 64'd0);
         end
         #300;
      end

      // Reset in the middle of a frame, with cs_n still low at release
      spi_shift(64'h0000_0ABC, 12, cap);
      check("mid_busy", {63'd0, host_if.spi_busy}, 64'd1);
      #7 rst_n = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("midrst");
      @(posedge clk);
      #5 rst_n = 1'b1;
      #500;
      check("no_start_after_rst", {63'd0, host_if.spi_busy}, 64'd0);
      cs_n = 1'b1;
      #400;
      spi_shift(64'h2C00_0000, 32, cap);
      end_frame(1'b0, 1'b0);
      check("post_rst_rx",  {32'd0, host_if.rx_output}, 64'h2C00_0000);
      check("post_rst_rdy", {63'd0, host_if.rdy_spi},   64'd1);
      check("post_rst_ovr", {63'd0, host_if.overrun},   64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
